vga_sync_controller: RTL and testbench
======================================

// Module: vga_sync_controller
// PURPOSE
//  Generates 640x480@60Hz VGA timing from the 100 MHz board clock: pixel-rate tick, active-low
//  hsync/vsync and the live pixel coordinate (x, y) with video_on. Sits directly upstream of
//  pixel_generation, which consumes video_on/x/y. hsync/vsync drive the VGA connector pins.
// PARAMETERS
//  DIV  4    clk_100MHz cycles per pixel (25 MHz pixel rate); legal 2..16
//  HD   640  horizontal display pixels
//  HF   16   horizontal front porch
//  HS   96   horizontal sync width
//  HB   48   horizontal back porch (H total = HD+HF+HS+HB = 800)
//  VD   480  vertical display lines
//  VF   10   vertical front porch
//  VS   2    vertical sync width
//  VB   33   vertical back porch (V total = 525)
// PORTS
//  clk_100MHz  in   1   system clock, all logic rising-edge
//  reset_n     in   1   asynchronous active-low reset
//  p_tick      out  1   1-clk pulse every DIV clks; marks cycle where new x/y/sync first valid
//  frame_tick  out  1   1-clk pulse coincident with p_tick when (x,y) becomes (0,0)
//  hsync       out  1   horizontal sync, active low
//  vsync       out  1   vertical sync, active low
//  video_on    out  1   1 when x<HD and y<VD
//  x           out  10  horizontal pixel counter, 0..HD+HF+HS+HB-1
//  y           out  10  vertical line counter, 0..VD+VF+VS+VB-1
// BEHAVIOUR
//  - Reset (async assert, sync-safe release): div_cnt=0, x=799, y=524, hsync=1, vsync=1,
//    video_on=0, p_tick=0, frame_tick=0. Parking at last position makes first pixel step land on (0,0).
//  - div_cnt counts 0..DIV-1, wraps. Internal en = (div_cnt==DIV-1). First en on 4th edge after release.
//  - On edge with en: x <= (x==799)?0:x+1; y advances only when x==799: y <= (y==524)?0:y+1.
//  - hsync/vsync/video_on are registers loaded on the same en edge from the NEXT x/y values, so
//    all outputs describe the same pixel and are glitch-free. No extra pipeline latency vs x/y.
//  - hsync=0 iff 656<=x<=751 (HD+HF .. HD+HF+HS-1); vsync=0 iff 490<=y<=491.
//  - p_tick, frame_tick registered: p_tick=1 in the clk cycle after each en edge, else 0;
//    frame_tick=1 in that same cycle only if new (x,y)==(0,0).
//  - Between en edges all outputs hold. Frame = 800*525*DIV = 1,680,000 clks.
//  - Reset mid-frame: immediate return to reset values regardless of div_cnt/x/y; restarts cleanly.
//  - Counter widths fixed at 10 bits; compare against totals, never rely on natural overflow.
// STRUCTURE
//  - Timing constants (HD..VB, H_TOTAL, V_TOTAL, sync start/end) in shared include
//    vga_timing.vh, also used by pixel_generation and future text/sprite stages.
//  - One natural sub-module: vga_pixel_tick (div_cnt + en), reusable by other VGA blocks.
//  - Remainder is two counters plus output registers; single always block per register group.
// TESTING
//  1 Reset release, count edges -> first p_tick high in cycle after 4th edge; x=0,y=0,video_on=1,
//    frame_tick=1, hsync=vsync=1.
//  2 Run one line -> p_tick period exactly 4 clks; x 0..799 then 0, y 0->1 at wrap; video_on falls at x=640.
//  3 Check hsync -> low for exactly 96 pixels, x=656..751; high at x=655 and x=752.
//  4 Run one full frame -> vsync low only on y=490,491 (1600 pixels); next frame_tick exactly
//    1,680,000 clks after first; video_on=0 for all y>=480.
//  5 Assert reset_n mid-line (x=300,y=200, div_cnt=2) -> outputs take reset values asynchronously
//    without waiting for clk; after release sequence identical to scenario 1.
//  6 Assertion-based: video_on never 1 while hsync or vsync low; x<800, y<525 at all times.

Source files
------------

// File: rtl/vga_sync_controller_pkg.sv
// Shared 640x480@60Hz VGA timing constants and a small window-compare helper
// used by the sync controller and downstream pixel stages.
package vga_sync_controller_pkg;

    localparam int CNT_W   = 10;
    localparam int DIV_DEF = 4;

    localparam int H_DISP_DEF  = 640;
    localparam int H_FRONT_DEF = 16;
    localparam int H_SYNC_DEF  = 96;
    localparam int H_BACK_DEF  = 48;

    localparam int V_DISP_DEF  = 480;
    localparam int V_FRONT_DEF = 10;
    localparam int V_SYNC_DEF  = 2;
    localparam int V_BACK_DEF  = 33;

    // True when pos lies in the inclusive window [first, last].
    function automatic logic in_window(input logic [CNT_W-1:0] pos,
                                       input int first, input int last);
        return (int'(pos) >= first) && (int'(pos) <= last);
    endfunction

endpackage

// File: rtl/vga_sync_controller_pixel_tick.sv
// Pixel-rate enable: divides the system clock by DIV, asserting en for one
// clock at the end of every DIV-clock period.
module vga_pixel_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    output logic en
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] div_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (div_cnt == LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign en = (div_cnt == LAST);

endmodule

// File: rtl/vga_sync_controller.sv
// VGA timing generator: pixel/line counters plus registered sync, video_on
// and tick outputs, all updated together on each pixel-rate enable.
module vga_sync_controller
    import vga_sync_controller_pkg::*;
#(
    parameter int DIV = DIV_DEF,
    parameter int HD  = H_DISP_DEF,
    parameter int HF  = H_FRONT_DEF,
    parameter int HS  = H_SYNC_DEF,
    parameter int HB  = H_BACK_DEF,
    parameter int VD  = V_DISP_DEF,
    parameter int VF  = V_FRONT_DEF,
    parameter int VS  = V_SYNC_DEF,
    parameter int VB  = V_BACK_DEF
) (
    input  logic             clk_100MHz,
    input  logic             reset_n,
    output logic             p_tick,
    output logic             frame_tick,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y
);

    localparam int H_TOTAL      = HD + HF + HS + HB;
    localparam int V_TOTAL      = VD + VF + VS + VB;
    localparam int H_SYNC_FIRST = HD + HF;
    localparam int H_SYNC_LAST  = HD + HF + HS - 1;
    localparam int V_SYNC_FIRST = VD + VF;
    localparam int V_SYNC_LAST  = VD + VF + VS - 1;

    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_TOTAL - 1);

    logic             en;
    logic [CNT_W-1:0] x_next;
    logic [CNT_W-1:0] y_next;

    vga_pixel_tick #(.DIV(DIV)) u_pixel_tick (
        .clk     (clk_100MHz),
        .reset_n (reset_n),
        .en      (en)
    );

    always_comb begin
        x_next = x;
        y_next = y;
        if (en) begin
            if (x == X_LAST) begin
                x_next = '0;
                y_next = (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
                x_next = x + 1'b1;
            end
        end
    end

    // Parked on the last position so the first enable lands on (0,0).
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            x <= X_LAST;
            y <= Y_LAST;
        end else begin
            x <= x_next;
            y <= y_next;
        end
    end

    // Decoded from the next position so these stay aligned with x/y.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            video_on <= 1'b0;
        end else if (en) begin
            hsync    <= !in_window(x_next, H_SYNC_FIRST, H_SYNC_LAST);
            vsync    <= !in_window(y_next, V_SYNC_FIRST, V_SYNC_LAST);
            video_on <= (int'(x_next) < HD) && (int'(y_next) < VD);
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            p_tick     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            p_tick     <= en;
            frame_tick <= en && (x_next == '0) && (y_next == '0);
        end
    end

endmodule

// File: tb/tb_vga_sync_controller.sv
// Directed bench for vga_sync_controller: full horizontal timing, shortened
// vertical timing so a whole frame fits in a short run.
module tb_vga_sync_controller;

    localparam int DIV = 4;
    localparam int VD  = 6;
    localparam int VF  = 2;
    localparam int VS  = 2;
    localparam int VB  = 2;
    localparam int V_TOTAL = VD + VF + VS + VB;   // 12 lines
    localparam int H_TOTAL = 800;
    localparam int FRAME_CLKS = H_TOTAL * V_TOTAL * DIV;

    logic       clk;
    logic       reset_n;
    logic       p_tick, frame_tick, hsync, vsync, video_on;
    logic [9:0] x, y;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int cyc_frame0 = 0;
    bit monitor_on = 0;
    int ex, ey;

    vga_sync_controller #(
        .DIV(DIV), .VD(VD), .VF(VF), .VS(VS), .VB(VB)
    ) dut (
        .clk_100MHz (clk),
        .reset_n    (reset_n),
        .p_tick     (p_tick),
        .frame_tick (frame_tick),
        .hsync      (hsync),
        .vsync      (vsync),
        .video_on   (video_on),
        .x          (x),
        .y          (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Invariants checked every cycle while running.
    always @(negedge clk) begin
        if (monitor_on && reset_n) begin
            checks++;
            if (video_on && (!hsync || !vsync)) begin
                failures++;
                $display("FAIL inv_video_sync: video_on=%b hsync=%b vsync=%b x=%0d y=%0d",
                         video_on, hsync, vsync, x, y);
            end
            checks++;
            if (x >= H_TOTAL || y >= V_TOTAL) begin
                failures++;
                $display("FAIL inv_range: x=%0d y=%0d limits 800/%0d", x, y, V_TOTAL);
            end
        end
    end

    // Waits for the next p_tick (sampled 1ns after each edge), bounded.
    task automatic next_pixel(output int clks);
        clks = 0;
        do begin
            @(posedge clk);
            #1;
            clks++;
        end while (!p_tick && clks < 4 * DIV);
    endtask

    task automatic advance_model();
        if (ex == H_TOTAL - 1) begin
            ex = 0;
            ey = (ey == V_TOTAL - 1) ? 0 : ey + 1;
        end else begin
            ex = ex + 1;
        end
    endtask

    // Releases reset and checks the first four edges.
    task automatic check_startup();
        @(negedge clk);
        reset_n = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            if (e < 4) begin
                checks++;
                if (p_tick !== 1'b0 || x !== 10'd799) begin
                    failures++;
                    $display("FAIL startup_hold edge%0d: p_tick=%b x=%0d required p_tick=0 x=799",
                             e, p_tick, x);
                end
            end else begin
                checks++;
                if (p_tick !== 1'b1 || frame_tick !== 1'b1) begin
                    failures++;
                    $display("FAIL startup_ticks: p_tick=%b frame_tick=%b required 1/1",
                             p_tick, frame_tick);
                end
                checks++;
                if (x !== 10'd0 || y !== 10'd0) begin
                    failures++;
                    $display("FAIL startup_pos: x=%0d y=%0d required 0/0", x, y);
                end
                checks++;
                if (video_on !== 1'b1 || hsync !== 1'b1 || vsync !== 1'b1) begin
                    failures++;
                    $display("FAIL startup_out: video_on=%b hsync=%b vsync=%b required 1/1/1",
                             video_on, hsync, vsync);
                end
            end
        end
        cyc_frame0 = cyc;
        ex = 0;
        ey = 0;
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (x !== 10'd799 || y !== 10'(V_TOTAL - 1)) begin
            failures++;
            $display("FAIL %s_pos: x=%0d y=%0d required 799/%0d", tag, x, y, V_TOTAL - 1);
        end
        checks++;
        if (hsync !== 1'b1 || vsync !== 1'b1 || video_on !== 1'b0 ||
            p_tick !== 1'b0 || frame_tick !== 1'b0) begin
            failures++;
            $display("FAIL %s_out: hs=%b vs=%b von=%b pt=%b ft=%b required 1/1/0/0/0",
                     tag, hsync, vsync, video_on, p_tick, frame_tick);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        check_startup();
        monitor_on = 1;
    endtask

    task automatic test_line();
        int c;
        int hs_low = 0;
        bit exp_hs, exp_von;
        for (int i = 1; i <= H_TOTAL; i++) begin
            next_pixel(c);
            advance_model();
            exp_hs  = !(ex >= 656 && ex <= 751);
            exp_von = (ex < 640) && (ey < VD);
            checks++;
            if (c != DIV) begin
                failures++;
                $display("FAIL line_period: step %0d took %0d clks required %0d", i, c, DIV);
            end
            checks++;
            if (x !== 10'(ex) || y !== 10'(ey)) begin
                failures++;
                $display("FAIL line_pos: x=%0d y=%0d required %0d/%0d", x, y, ex, ey);
            end
            checks++;
            if (hsync !== exp_hs || video_on !== exp_von || vsync !== 1'b1) begin
                failures++;
                $display("FAIL line_out x=%0d: hs=%b von=%b vs=%b required %b/%b/1",
                         ex, hsync, video_on, vsync, exp_hs, exp_von);
            end
            if (hsync === 1'b0) hs_low++;
        end
        checks++;
        if (hs_low != 96) begin
            failures++;
            $display("FAIL hsync_width: low for %0d pixels required 96", hs_low);
        end
    endtask

    task automatic test_frame();
        int c;
        int steps = 0;
        int vs_low = 0;
        bit done = 0;
        bit exp_vs, exp_von, exp_ft;
        for (int i = 0; i < H_TOTAL * V_TOTAL && !done; i++) begin
            next_pixel(c);
            advance_model();
            steps++;
            exp_vs  = !(ey >= VD + VF && ey <= VD + VF + VS - 1);
            exp_von = (ex < 640) && (ey < VD);
            exp_ft  = (ex == 0) && (ey == 0);
            checks++;
            if (c != DIV || x !== 10'(ex) || y !== 10'(ey)) begin
                failures++;
                $display("FAIL frame_step: clks=%0d x=%0d y=%0d required %0d/%0d/%0d",
                         c, x, y, DIV, ex, ey);
            end
            checks++;
            if (vsync !== exp_vs || video_on !== exp_von || frame_tick !== exp_ft) begin
                failures++;
                $display("FAIL frame_out x=%0d y=%0d: vs=%b von=%b ft=%b required %b/%b/%b",
                         ex, ey, vsync, video_on, frame_tick, exp_vs, exp_von, exp_ft);
            end
            if (vsync === 1'b0) vs_low++;
            if (frame_tick === 1'b1) done = 1;
        end
        checks++;
        if (!done || steps != H_TOTAL * (V_TOTAL - 1)) begin
            failures++;
            $display("FAIL frame_len: done=%0b steps=%0d required 1/%0d",
                     done, steps, H_TOTAL * (V_TOTAL - 1));
        end
        checks++;
        if (vs_low != H_TOTAL * VS) begin
            failures++;
            $display("FAIL vsync_width: low for %0d pixels required %0d", vs_low, H_TOTAL * VS);
        end
        checks++;
        if (cyc - cyc_frame0 != FRAME_CLKS) begin
            failures++;
            $display("FAIL frame_period: %0d clks required %0d", cyc - cyc_frame0, FRAME_CLKS);
        end
    endtask

    task automatic test_reset_midline();
        int c;
        for (int i = 0; i < 3 * H_TOTAL + 300; i++) begin
            next_pixel(c);
            advance_model();
        end
        checks++;
        if (x !== 10'd300 || y !== 10'd3) begin
            failures++;
            $display("FAIL midline_pos: x=%0d y=%0d required 300/3", x, y);
        end
        // Two edges past the tick leaves the divider at 2.
        @(posedge clk);
        @(posedge clk);
        #2;
        monitor_on = 0;
        reset_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset_hold");
        check_startup();
        monitor_on = 1;
    endtask

    task automatic test_back_to_back();
        int c;
        for (int i = 1; i <= 3; i++) begin
            next_pixel(c);
            checks++;
            if (c != DIV || x !== 10'(i) || y !== 10'd0 || frame_tick !== 1'b0) begin
                failures++;
                $display("FAIL restart_step%0d: clks=%0d x=%0d y=%0d ft=%b required %0d/%0d/0/0",
                         i, c, x, y, frame_tick, DIV, i);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        test_reset();
        test_line();
        test_frame();
        test_reset_midline();
        test_back_to_back();
        monitor_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
